// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Parses a framed program image from a UART byte stream and writes it into
// instruction memory, one 32-bit word per write. When the checksum matches,
// it releases the core from reset.
// Frame: 0xA5, LEN (16-bit LE word count), LEN*4 data bytes (LE words),
// CSUM (8-bit sum of the data bytes).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rx_valid, rx_data     received byte strobe and data (no backpressure)
//   imem_we/addr/wdata    instruction memory write port (registered)
//   core_rst_n            active-low core reset, released after a good load
//   busy                  frame in progress
//   done                  sticky load-complete flag
//   error                 sticky abort flag, cleared by the next header byte
//
// state  | meaning
// IDLE   | waiting for header, core held in reset
// LEN0   | expecting LEN low byte
// LEN1   | expecting LEN high byte, range check
// DATA   | assembling and writing words
// CSUM   | expecting checksum byte
// DONE   | image loaded, core running; header restarts a load
module imem_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_LEN = 17'(2 ** ADDR_WIDTH);
  localparam logic [7:0]      HDR     = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           left_q, left_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [15:0] len_w;
  logic        in_frame;

  assign len_w    = {rx_data, len_lo_q};
  assign in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    left_d       = left_q;
    widx_d       = widx_q;
    bidx_d       = bidx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    tmo_d        = '0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    error_d      = error_q;

    if (in_frame && !rx_valid) tmo_d = tmo_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HDR) begin
          error_d = 1'b0;
          state_d = S_LEN0;
        end
      end
      S_LEN0: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (rx_valid) begin
          left_d = len_w;
          widx_d = '0;
          bidx_d = '0;
          csum_d = '0;
          if ({1'b0, len_w} > MAX_LEN) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else if (len_w == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q + rx_data;
          // Bytes enter from the top, so after three bytes word_q holds
          // {b2,b1,b0}: each byte ends up at bit position byte_index*8.
          word_d = {rx_data, word_q[23:8]};
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = widx_q;
            imem_wdata_d = {rx_data, word_q};
            widx_d       = widx_q + 1'b1;
            left_d       = left_q - 16'd1;
            if (left_q == 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (rx_valid && rx_data == HDR) begin
          core_rst_n_d = 1'b0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          state_d      = S_LEN0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter sat at TIMEOUT_CYCLES-1 and another idle cycle passed.
    if (in_frame && !rx_valid && tmo_q == TO_LAST) begin
      error_d = 1'b1;
      state_d = S_IDLE;
      tmo_d   = '0;
    end

    busy_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
             (state_d == S_DATA) || (state_d == S_CSUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      left_q       <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      left_q       <= left_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader with a small memory (16 words) and a short
// timeout (16 cycles). Frames are built as byte queues; expected writes
// and flags are derived from the frame contents by plain arithmetic.
module tb_imem_loader;

  localparam int AW = 4;
  localparam int TO = 16;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          error;

  int tests    = 0;
  int fails    = 0;
  int we_count = 0;

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Each cycle with imem_we high counts as one write.
  always @(posedge clk) begin
    #2;
    if (imem_we === 1'b1) we_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, after the byte's edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    {31'd0, imem_we},    32'd0);
    check({tag, "_addr"},  {28'd0, imem_addr},  32'd0);
    check({tag, "_wdata"}, imem_wdata,          32'd0);
    check({tag, "_core"},  {31'd0, core_rst_n}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_done"},  {31'd0, done},       32'd0);
    check({tag, "_err"},   {31'd0, error},      32'd0);
  endtask

  function automatic bq_t mk_frame(input int len, input bit bad);
    bq_t        q;
    logic [7:0] s;
    logic [7:0] b;
    logic [15:0] l16;
    s   = 8'd0;
    l16 = 16'(len);
    q.push_back(8'hA5);
    q.push_back(l16[7:0]);
    q.push_back(l16[15:8]);
    if (len <= (1 << AW)) begin
      for (int i = 0; i < 4 * len; i++) begin
        b = 8'($urandom_range(0, 255));
        s = s + b;
        q.push_back(b);
      end
      q.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
    end
    return q;
  endfunction

  task automatic run_frame(input bq_t fr, input int gapmax);
    int         len, nd, w0, n;
    bit         over, ok;
    logic [7:0] s;
    n    = fr.size();
    len  = int'({fr[2], fr[1]});
    over = len > (1 << AW);
    nd   = over ? 0 : 4 * len;
    w0   = we_count;
    s    = 8'd0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && gapmax > 0) idle($urandom_range(0, gapmax));
      send_byte(fr[i]);
      if (i == 0) begin
        check("hdr_busy", {31'd0, busy},       32'd1);
        check("hdr_done", {31'd0, done},       32'd0);
        check("hdr_core", {31'd0, core_rst_n}, 32'd0);
        check("hdr_err",  {31'd0, error},      32'd0);
      end
      if (i >= 3 && i < 3 + nd) s = s + fr[i];
      if (i >= 3 && i < 3 + nd && ((i - 3) % 4) == 3) begin
        check("wr_we",    {31'd0, imem_we},   32'd1);
        check("wr_addr",  {28'd0, imem_addr}, 32'((i - 3) / 4));
        check("wr_wdata", imem_wdata,         {fr[i], fr[i-1], fr[i-2], fr[i-3]});
      end else begin
        check("no_we", {31'd0, imem_we}, 32'd0);
      end
    end
    ok = !over && (fr[n-1] == s);
    check("end_done",   {31'd0, done},       {31'd0, ok});
    check("end_core",   {31'd0, core_rst_n}, {31'd0, ok});
    check("end_err",    {31'd0, error},      {31'd0, !ok});
    check("end_busy",   {31'd0, busy},       32'd0);
    check("end_writes", 32'(we_count - w0),  over ? 32'd0 : 32'(len));
  endtask

  initial begin
    bq_t fa, fb, fz, fo, fr;
    int  w0, len;

    fa = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    fb = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'hB5};
    fz = '{8'hA5, 8'h00, 8'h00, 8'h00};
    fo = '{8'hA5, 8'h11, 8'h00};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    check_reset_vals("rst");
    rst_n = 1'b1;
    idle(1);

    // Normal load with gaps, then back-to-back (reload from DONE).
    run_frame(fa, 3);
    run_frame(fa, 0);

    // Bad checksum, then recovery.
    run_frame(fb, 2);
    run_frame(fa, 0);

    // Garbage prefix ignored, zero-length frame.
    w0 = we_count;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("garb_busy", {31'd0, busy}, 32'd0);
    check("garb_done", {31'd0, done}, 32'd1);
    check("garb_wr",   32'(we_count - w0), 32'd0);
    run_frame(fz, 1);

    // Timeout: error exactly TO cycles after the last strobe.
    send_byte(8'hA5);
    send_byte(8'h02);
    idle(TO - 1);
    check("to_early", {31'd0, error}, 32'd0);
    check("to_busy1", {31'd0, busy},  32'd1);
    idle(1);
    check("to_err",   {31'd0, error}, 32'd1);
    check("to_busy0", {31'd0, busy},  32'd0);
    check("to_done",  {31'd0, done},  32'd0);
    run_frame(fa, 1);

    // Oversize rejected; full-capacity frame accepted (last write addr 15).
    run_frame(fo, 2);
    run_frame(mk_frame(1 << AW, 1'b0), 1);

    // Asynchronous reset mid-DATA.
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
    check("mid_we", {31'd0, imem_we}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    run_frame(fa, 2);

    // Randomized frames.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 7) == 0) len = $urandom_range((1 << AW) + 1, 65535);
      else                           len = $urandom_range(0, 1 << AW);
      fr = mk_frame(len, $urandom_range(0, 3) == 0);
      run_frame(fr, $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
